pipe_mux: RTL and testbench
===========================

# pipe_mux

Parametrised N-input, WIDTH-bit registered multiplexer stage with a valid/ready handshake and a two-entry skid buffer. It generalises the combinational 2:1/3:1 operand muxes into a pipelined select stage for datapaths such as forwarding and writeback select. Downstream stalls are absorbed without a combinational ready path, and out-of-range selects are flagged. Out-of-range selects still yield zero data.

## Interface

- WIDTH, 32, data width of each input and of the output
- N, 3, number of inputs; legal range 1..64
- SELW, derived as (N>1) ? $clog2(N) : 1, select width; not overridden by the instantiator

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_flat  input  N*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  input  SELW  select, sampled with in_valid
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- flush  input  1  synchronous discard of all held beats
- out_data  output  WIDTH  selected data
- out_sel_err  output  1  sideband: this beat had sel >= N
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- err_count  output  8  saturating count of accepted beats with sel >= N

## Operation

- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- Beat value on accept:
  - data = input[sel] if sel < N, else all-zero.
  - err = (sel >= N).
- Storage: main register {data, err, valid} drives the outputs directly. Skid register {data, err, valid} holds one overflow beat.
- State is the valid-bit pair, with three states:
  - EMPTY, main invalid.
  - ONE, main valid and skid empty.
  - TWO, main and skid both valid.
- EMPTY:
  - accept -> ONE, main <= beat.
  - otherwise stay.
- ONE:
  - accept && pop -> ONE, main <= beat.
  - accept && !pop -> TWO, skid <= beat.
  - pop && !accept -> EMPTY.
  - neither -> stay.
- TWO:
  - No accepts, since in_ready=0.
  - pop -> ONE, main <= skid, skid cleared.
  - no pop -> stay.
- in_ready = !skid_valid && !flush.
  - Depends only on registered state and flush, never on out_ready.
- flush, highest priority:
  - The next state is EMPTY and both valid bits clear.
  - A pop in the same cycle counts as completed.
  - No accept occurs, because in_ready is forced low.
- err_count:
  - +1 on each accept with sel >= N; saturates at 255.
  - Not cleared by flush; cleared only by reset.
- Beat order is strictly FIFO; no beat is duplicated or dropped except by flush.

## Timing

- Reset while rst_n is low (asynchronous assert; release takes effect at the next edge):
  - out_valid=0, out_data=0, out_sel_err=0, err_count=0.
  - skid cleared.
  - in_ready=1 (when flush=0).
- Latency: a beat accepted at edge t appears on out_valid/out_data after edge t, in the same cycle as the next accept opportunity.
- Throughput: one beat per cycle when out_ready is held high.
- Stall: while out_valid && !out_ready, out_data and out_sel_err hold stable.
- Stall takeover: one more beat is absorbed into the skid, then in_ready drops on the following cycle.
- in_ready rises the cycle after the pop that empties the skid.
- Reset mid-operation discards all beats immediately; err_count returns to 0.
- N=1: sel=0 selects input 0 and sel=1 is an error.
- N a power of two: out_sel_err is never set.

## Test plan

- **Reset:** assert rst_n=0 mid-stream with two beats held -> out_valid=0, out_data=0, err_count=0, in_ready=1 immediately; no stale beat after release.
- **Streaming:** N=3, WIDTH=32, in_flat={0xCCCC_CCCC,0xBBBB_BBBB,0xAAAA_AAAA}, sel=0,1,2 on consecutive cycles, out_ready=1 -> out_data 0xAAAA_AAAA, 0xBBBB_BBBB, 0xCCCC_CCCC on the following three cycles; in_ready constantly 1.
- **Illegal select:** sel=3 with N=3 -> out_data=0, out_sel_err=1, err_count=1; then 300 such beats -> err_count saturates at 255.
- **Stall and skid:** out_ready=0 while sending beats 0x11 then 0x22 -> in_ready=0 after the second accept; 0x11 holds on out_data. Then raise out_ready -> 0x11 pops, then 0x22 pops; in_ready returns to 1 one cycle after the skid empties.
- **Flush:** flush=1 with both registers full and in_valid=1 -> next cycle out_valid=0, in_ready=1; no beat from the flush cycle emerges; err_count unchanged.
- **Random back-pressure:** random in_valid/out_ready over 10k beats, N=5 -> output sequence equals the accepted input sequence with the mux applied, and no handshake-rule violations.

Source files
------------

// File: rtl/pipe_mux.sv
// pipe_mux: registered N-input, WIDTH-bit select stage with a valid/ready
// handshake and a two-entry skid buffer (main + skid register).
//
// The main register drives the outputs directly. The skid register absorbs
// the one beat that can arrive while the downstream is stalled. Because
// in_ready comes only from registered state (and flush), the stage breaks
// the combinational ready path.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_flat         N packed inputs, input k at [k*WIDTH +: WIDTH]
//   sel             input select, sampled together with in_valid
//   in_valid/ready  upstream handshake
//   flush           synchronous discard of every held beat
//   out_data        selected data (zero when sel >= N)
//   out_sel_err     sideband flag: this beat had sel >= N
//   out_valid/ready downstream handshake
//   err_count       saturating count of accepted out-of-range selects
module pipe_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_flat,
  input  logic [SELW-1:0]      sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_sel_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           err_count
);

  // One extra bit so that N = 2**SELW still fits in the limit constant.
  localparam logic [SELW:0] N_LIM = (SELW + 1)'(N);

  // Encoding is the {skid_valid, main_valid} pair.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  function automatic logic [WIDTH-1:0] mux_sel(input logic [N*WIDTH-1:0] flat,
                                               input logic [SELW-1:0]    s);
    logic [WIDTH-1:0] r;
    r = '0;
    // Explicit compare per input keeps out-of-range selects at zero instead
    // of indexing past the packed vector.
    for (int k = 0; k < N; k++) begin
      if (s == SELW'(k)) r = flat[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_t           state, state_n;
  logic [WIDTH-1:0] beat_data_p0;
  logic             beat_err_p0;
  logic [WIDTH-1:0] data_p1, skid_data_p1;
  logic             err_p1, skid_err_p1;
  logic             accept, pop;
  logic             ld_main_beat, ld_main_skid, ld_skid_beat;
  logic [7:0]       err_cnt;

  // ---- stage p0: select the incoming beat ----
  assign beat_data_p0 = mux_sel(in_flat, sel);
  assign beat_err_p0  = ({1'b0, sel} >= N_LIM);

  assign in_ready  = (state != TWO) && !flush;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_n      = state;
    ld_main_beat = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_beat = 1'b0;
    if (flush) begin
      // A concurrent pop still completes; accept is already blocked.
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_n      = ONE;
            ld_main_beat = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            ld_main_beat = 1'b1;
          end else if (accept) begin
            state_n      = TWO;
            ld_skid_beat = 1'b1;
          end else if (pop) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_n      = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_n;
  end

  // ---- stage p1: main and skid registers ----
  // Main data is reset because out_data must read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else if (ld_main_beat) begin
      data_p1 <= beat_data_p0;
      err_p1  <= beat_err_p0;
    end else if (ld_main_skid) begin
      data_p1 <= skid_data_p1;
      err_p1  <= skid_err_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data_p1 <= '0;
      skid_err_p1  <= 1'b0;
    end else if (ld_skid_beat) begin
      skid_data_p1 <= beat_data_p0;
      skid_err_p1  <= beat_err_p0;
    end
  end

  // Survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      err_cnt <= 8'd0;
    else if (accept && beat_err_p0)  err_cnt <= sat_inc(err_cnt);
  end

  assign out_data    = data_p1;
  assign out_sel_err = err_p1;
  assign err_count   = err_cnt;

endmodule

// File: tb/tb_pipe_mux.sv
module tb_pipe_mux;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [2:0]   sel = '0;
  logic [159:0] in_flat5 = '0;
  logic [95:0]  in_flat3;

  logic         rdy3, oe3, ov3, rdy5, oe5, ov5;
  logic [31:0]  od3, od5;
  logic [7:0]   ec3, ec5;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  assign in_flat3 = in_flat5[95:0];

  always #5 clk = ~clk;

  pipe_mux #(.WIDTH(32), .N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat3), .sel(sel[1:0]),
    .in_valid(in_valid), .in_ready(rdy3), .flush(flush),
    .out_data(od3), .out_sel_err(oe3), .out_valid(ov3),
    .out_ready(out_ready), .err_count(ec3));

  pipe_mux #(.WIDTH(32), .N(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat5), .sel(sel),
    .in_valid(in_valid), .in_ready(rdy5), .flush(flush),
    .out_data(od5), .out_sel_err(oe5), .out_valid(ov5),
    .out_ready(out_ready), .err_count(ec5));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two beats per instance.
  logic [32:0] q3[$], q5[$];
  int  ec3_m = 0, ec5_m = 0, acc5 = 0;
  bit  a3, p3, a5, p5;

  function automatic logic [32:0] beat(input int n, input logic [159:0] flat, input int s);
    if (s >= n) return {1'b1, 32'h0};
    return {1'b0, flat[s*32 +: 32]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q3.delete(); q5.delete(); ec3_m = 0; ec5_m = 0;
    end else if (flush) begin
      q3.delete(); q5.delete();
    end else begin
      a3 = in_valid && (q3.size() < 2);
      p3 = out_ready && (q3.size() > 0);
      a5 = in_valid && (q5.size() < 2);
      p5 = out_ready && (q5.size() > 0);
      if (p3) void'(q3.pop_front());
      if (p5) void'(q5.pop_front());
      if (a3) begin
        q3.push_back(beat(3, in_flat5, int'(sel[1:0])));
        if (int'(sel[1:0]) >= 3 && ec3_m < 255) ec3_m++;
      end
      if (a5) begin
        q5.push_back(beat(5, in_flat5, int'(sel)));
        if (int'(sel) >= 5 && ec5_m < 255) ec5_m++;
        acc5++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("u3_valid", 64'(ov3), 64'(q3.size() != 0));
      if (q3.size() != 0) begin
        chk("u3_data", 64'(od3), 64'(q3[0][31:0]));
        chk("u3_err", 64'(oe3), 64'(q3[0][32]));
      end
      chk("u3_ready", 64'(rdy3), 64'((q3.size() < 2) && !flush));
      chk("u3_errcnt", 64'(ec3), 64'(ec3_m));
      chk("u5_valid", 64'(ov5), 64'(q5.size() != 0));
      if (q5.size() != 0) begin
        chk("u5_data", 64'(od5), 64'(q5[0][31:0]));
        chk("u5_err", 64'(oe5), 64'(q5[0][32]));
      end
      chk("u5_ready", 64'(rdy5), 64'((q5.size() < 2) && !flush));
      chk("u5_errcnt", 64'(ec5), 64'(ec5_m));
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic ordy, input logic fl);
    in_valid = v; sel = s; out_ready = ordy; flush = fl;
  endtask

  localparam logic [159:0] ABC = {32'hEEEE_EEEE, 32'hDDDD_DDDD, 32'hCCCC_CCCC,
                                   32'hBBBB_BBBB, 32'hAAAA_AAAA};
  localparam logic [159:0] V12 = {32'h0, 32'h0, 32'h0, 32'h22, 32'h11};

  initial begin
    int cyc;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 64'(ov3), 64'd0);
    chk("rst_data", 64'(od3), 64'd0);
    chk("rst_errcnt", 64'(ec3), 64'd0);
    chk("rst_ready", 64'(rdy3), 64'd1);
    rst_n = 1'b1;

    // Streaming through N=3
    in_flat5 = ABC;
    tick(); drive(1, 0, 1, 0);
    tick(); drive(1, 1, 1, 0);
    @(negedge clk); chk("stream0", 64'(od3), 64'hAAAA_AAAA); chk("stream_rdy", 64'(rdy3), 64'd1);
    tick(); drive(1, 2, 1, 0);
    @(negedge clk); chk("stream1", 64'(od3), 64'hBBBB_BBBB);
    tick(); drive(0, 0, 1, 0);
    @(negedge clk); chk("stream2", 64'(od3), 64'hCCCC_CCCC);

    // Illegal select, then saturation
    tick(); drive(1, 3, 1, 0);
    tick(); drive(0, 0, 1, 0);
    @(negedge clk);
    chk("ill_data", 64'(od3), 64'd0);
    chk("ill_err", 64'(oe3), 64'd1);
    chk("ill_cnt", 64'(ec3), 64'd1);
    chk("ill_u5_legal", 64'(od5), 64'hDDDD_DDDD);
    tick(); drive(1, 3, 1, 0);
    repeat (300) tick();
    drive(0, 0, 1, 0);
    tick();
    @(negedge clk); chk("ill_sat", 64'(ec3), 64'd255);

    // Stall and skid
    in_flat5 = V12;
    tick(); drive(1, 0, 0, 0);
    tick(); drive(1, 1, 0, 0);
    tick(); drive(0, 0, 0, 0);
    @(negedge clk);
    chk("stall_rdy", 64'(rdy3), 64'd0);
    chk("stall_hold", 64'(od3), 64'h11);
    tick();
    @(negedge clk); chk("stall_hold2", 64'(od3), 64'h11);
    drive(0, 0, 1, 0);
    tick();
    @(negedge clk);
    chk("skid_pop", 64'(od3), 64'h22);
    chk("skid_rdy", 64'(rdy3), 64'd1);
    tick();
    @(negedge clk); chk("skid_empty", 64'(ov3), 64'd0);

    // Flush with both registers full and in_valid high
    tick(); drive(1, 0, 0, 0);
    tick(); drive(1, 1, 0, 0);
    tick(); drive(1, 2, 0, 1);
    @(negedge clk); chk("flush_rdy_lo", 64'(rdy3), 64'd0);
    tick(); drive(0, 0, 1, 0);
    @(negedge clk);
    chk("flush_valid", 64'(ov3), 64'd0);
    chk("flush_rdy", 64'(rdy3), 64'd1);
    chk("flush_cnt", 64'(ec3), 64'd255);
    tick();
    @(negedge clk); chk("flush_nobeat", 64'(ov3), 64'd0);

    // Asynchronous reset with two beats held
    tick(); drive(1, 0, 0, 0);
    tick(); drive(1, 1, 0, 0);
    tick(); drive(0, 0, 0, 0);
    @(negedge clk); #1 rst_n = 1'b0; #1;
    chk("arst_valid", 64'(ov3), 64'd0);
    chk("arst_data", 64'(od3), 64'd0);
    chk("arst_cnt", 64'(ec3), 64'd0);
    chk("arst_rdy", 64'(rdy3), 64'd1);
    tick(); rst_n = 1'b1; drive(0, 0, 1, 0);
    tick();
    @(negedge clk); chk("arst_nostale", 64'(ov3), 64'd0);

    // Random back-pressure, mostly N=5 relevant
    acc5 = 0;
    cyc = 0;
    while (acc5 < 10000 && cyc < 40000) begin
      tick();
      in_flat5 = {$urandom, $urandom, $urandom, $urandom, $urandom};
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      cyc++;
    end
    chk("rand_beats_done", 64'(acc5 >= 10000), 64'd1);
    tick(); drive(0, 0, 1, 0);
    repeat (4) tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
